// File: rtl/dds_pkg.sv
// Shared DDS constants: default widths, dither LFSR polynomial/seed and
// the signed amplitude type used along the chain.
package dds_pkg;

    localparam int DDS_PHASE_WIDTH    = 32;
    localparam int DDS_LUT_ADDR_WIDTH = 8;
    localparam int DDS_AMP_WIDTH      = 16;

    // Right-shift Galois mask for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    typedef logic signed [DDS_AMP_WIDTH-1:0] amp_t;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude ROM, table built at elaboration,
// registered read port with clock enable.
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH = DDS_LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DDS_AMP_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int  DEPTH = 1 << ADDR_WIDTH;
    localparam real PI    = 3.14159265358979323846;

    // Half-LSB phase offset keeps the table symmetric and nonzero
    function automatic logic [DATA_WIDTH-1:0] entry(input int i);
        real x;
        x = (2.0 ** DATA_WIDTH - 1.0)
            * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(DEPTH));
        return DATA_WIDTH'($rtoi(x + 0.5));
    endfunction

    logic [DATA_WIDTH-1:0] tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        localparam logic [DATA_WIDTH-1:0] VAL = entry(i);
        assign tbl[i] = VAL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (en) begin
            data <= tbl[addr];
        end
    end

endmodule

// File: rtl/phase_to_sine.sv
// Phase word to signed sine sample, 3-stage valid/ready pipeline.
// Optional LFSR phase dither when PHASE_TO_SINE_DITHER_EN is defined.
module phase_to_sine
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH    = DDS_PHASE_WIDTH,
    parameter int LUT_ADDR_WIDTH = DDS_LUT_ADDR_WIDTH,
    parameter int AMP_WIDTH      = DDS_AMP_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PHASE_WIDTH-1:0] phase_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AMP_WIDTH-1:0]   sample_out
);

    localparam int D  = PHASE_WIDTH - 2 - LUT_ADDR_WIDTH;
    localparam int AW = LUT_ADDR_WIDTH;

    logic                   en;
    logic                   v1, v2, v3;
    logic [PHASE_WIDTH-1:0] phase_d;
    logic [AW+1:0]          top_bits;
    logic [AW-1:0]          addr_c, addr1;
    logic                   s1, s2;
    logic [AMP_WIDTH-2:0]   mag;
    logic [AMP_WIDTH-1:0]   mag_ext;
    logic [AMP_WIDTH-1:0]   sample_r;

    assign en         = !v3 || out_ready;
    assign in_ready   = en;
    assign out_valid  = v3;
    assign sample_out = sample_r;

`ifdef PHASE_TO_SINE_DITHER_EN
    logic [31:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (in_valid && en) begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
        end
    end

    // Carry out of the dither sum may bump address and quadrant
    assign phase_d = phase_in + PHASE_WIDTH'(D'(lfsr));
`else
    assign phase_d = phase_in;
`endif

    assign top_bits = (AW+2)'(phase_d >> D);
    assign addr_c   = top_bits[AW] ? ~top_bits[AW-1:0] : top_bits[AW-1:0];
    assign mag_ext  = {1'b0, mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            addr1    <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            sample_r <= '0;
        end else if (en) begin
            v1       <= in_valid;
            v2       <= v1;
            v3       <= v2;
            addr1    <= addr_c;
            s1       <= top_bits[AW+1];
            s2       <= s1;
            sample_r <= s2 ? -mag_ext : mag_ext;
        end
    end

    sine_quarter_rom #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (AMP_WIDTH - 1)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (addr1),
        .data (mag)
    );

endmodule

// File: tb/tb_phase_to_sine.sv
// Self-checking bench for phase_to_sine: directed vectors plus scoreboard.
module tb_phase_to_sine;
    import dds_pkg::*;

    localparam int  PW = 32;
    localparam int  AW = 16;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] phase_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] sample_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q[$];
    int tin_q[$];
    int outs[$];
    bit lat_on = 0;

    always #5 clk = ~clk;

    phase_to_sine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .phase_in   (phase_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_out (sample_out)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full-wave reference: 1024 phase bins, rounded half away from zero
    function automatic int model(input logic [31:0] ph);
        int  k;
        real x, r;
        k = int'(ph >> 22);
        x = 32767.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 1024.0);
        r = (x < 0.0) ? -x : x;
        return (x < 0.0) ? -$rtoi(r + 0.5) : $rtoi(r + 0.5);
    endfunction

    task automatic step();
        int e, t;
        #1;
        if (out_valid && out_ready) begin
            outs.push_back(int'($signed(sample_out)));
            if (exp_q.size() == 0) begin
                check("dup_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                t = tin_q.pop_front();
                check("sample", $signed(sample_out), e);
                if (lat_on) check("latency", cyc - t, 3);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(phase_in));
            tin_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int   qexp[4];
        logic [31:0] qph[4];
        logic [31:0] bp[3];
        amp_t held;

        qexp = '{101, 32767, -101, -32767};
        qph  = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        bp   = '{32'h1000_0000, 32'h5000_0000, 32'h9000_0000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        phase_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sample", $signed(sample_out), 0);
        rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);

        // Quadrant points
        lat_on = 1;
        out_ready = 1'b1;
        outs.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            phase_in = qph[i];
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        check("quad_count", outs.size(), 4);
        for (int i = 0; i < 4 && i < outs.size(); i++)
            check("quad_value", outs[i], qexp[i]);

        // Streaming full turn
        outs.delete();
        for (int i = 0; i < 259; i++) begin
            in_valid = (i < 256);
            phase_in = 32'(i) << 24;
            if (i >= 3) check("stream_valid", out_valid, 1);
            step();
        end
        in_valid = 1'b0;
        check("stream_count", outs.size(), 256);
        if (outs.size() == 256)
            for (int k = 0; k < 128; k++)
                check("odd_sym", outs[k + 128], -outs[k]);

        // Backpressure with 3 samples in flight
        lat_on = 0;
        outs.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            phase_in = bp[i];
            step();
        end
        check("bp_valid", out_valid, 1);
        held = amp_t'(sample_out);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            phase_in = $urandom;
            #1;
            check("bp_ready", in_ready, 0);
            check("bp_hold", $signed(sample_out), held);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("bp_count", outs.size(), 3);
        for (int i = 0; i < 3 && i < outs.size(); i++)
            check("bp_order", outs[i], model(bp[i]));

        // Reset with samples in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        phase_in = 32'h1000_0000;
        step();
        phase_in = 32'h5000_0000;
        step();
        in_valid = 1'b0;
        step();
        check("mid_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_valid", out_valid, 0);
        check("mid_sample", $signed(sample_out), 0);
        exp_q.delete();
        tin_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            check("mid_stale", out_valid, 0);
            step();
        end

`ifndef PHASE_TO_SINE_DITHER_EN
        // Random handshake with scoreboard
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            phase_in = $urandom;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("drop", exp_q.size(), 0);
`else
        begin
            logic [31:0] m;
            rst = 1'b1;
            #1;
            rst = 1'b0;
            m = 32'h1;
            out_ready = 1'b1;
            in_valid = 1'b1;
            phase_in = 32'h2000_0000;
            for (int i = 0; i < 64; i++) begin
                #1;
                check("lfsr", dut.lfsr, m);
                m = (m >> 1) ^ (m[0] ? 32'h8020_0003 : 32'h0);
                if (i >= 3) check("dither_sample", $signed(sample_out), model(32'h2000_0000));
                step();
            end
            in_valid = 1'b0;
            repeat (5) step();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/phase_to_sine.md
Name: phase_to_sine

Overview:
- Downstream stage of the phase accumulator. Converts an unsigned phase word into a signed sine amplitude.
- Uses a quarter-wave LUT.
- Valid/ready handshake on both sides, 3-stage pipeline with full backpressure.
- Feeds the DAC/output formatting stage of the DDS chain.

Parameters:
- PHASE_WIDTH, 32, width of incoming phase word
- LUT_ADDR_WIDTH, 8, quarter-wave table address bits (2^LUT_ADDR_WIDTH entries)
- AMP_WIDTH, 16, signed output amplitude width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  phase_in valid
- in_ready  output  1  stage can accept phase_in
- phase_in  input  PHASE_WIDTH  unsigned phase, full scale = 2*pi
- out_valid  output  1  sample_out valid
- out_ready  input  1  downstream accepts sample_out
- sample_out  output  AMP_WIDTH  two's-complement sine sample

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset state: all stage valid bits 0, all data registers 0. Therefore out_valid=0, sample_out=0, and in_ready=1 once rst deasserts.
- Advance enable: en = !v3 || out_ready, where v3 is the stage-3 valid bit.
  - in_ready = en.
  - All three stages shift together when en=1 and hold when en=0.
  - Bubbles are not collapsed.
- Transfer rules: input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Stage validity: v1 <= in_valid&&en, v2 <= v1, v3 <= v2, each updated only when en=1.
- Throughput and latency: one sample per clock when out_ready is held high. Latency is 3 cycles from input transfer to out_valid.
- S1 (address decode):
  - q = phase_in[PW-1:PW-2].
  - a = phase_in[PW-3 -: LUT_ADDR_WIDTH].
  - If q[0]=1 then a = ~a (mirror).
  - Register a and sign bit q[1].
  - Lower phase bits are discarded by truncation.
- S2 (table read):
  - Registered ROM read: mag = LUT[a], AMP_WIDTH-1 bits, unsigned.
  - LUT[i] = round((2^(AMP_WIDTH-1)-1) * sin(pi/2*(i+0.5)/2^LUT_ADDR_WIDTH)).
  - The half-LSB offset makes the table symmetric, so no extra entry is needed and mag never reaches 0.
  - The table is generated at elaboration.
- S3 (sign apply): sample_out = sign ? -mag : +mag, zero-extended before negation. The result is never -2^(AMP_WIDTH-1).
- Phase wrap: wrap-around of the phase word needs no special handling; quadrant decode covers it.
- Stall behaviour:
  - When out_valid=1 and out_ready=0, sample_out is stable and in_ready=0.
  - in_valid may toggle during a stall without any effect.
- Reset mid-operation: all in-flight samples are dropped. Nothing is emitted after rst falls until new inputs arrive.

Optional Feature:
- Macro: PHASE_TO_SINE_DITHER_EN.
- Enabled:
  - A 32-bit Galois LFSR steps once per input transfer. Polynomial x^32+x^22+x^2+x+1, seed 32'h1, and it is reset to the seed.
  - Its low D bits are added to the discarded phase LSBs, with D = PHASE_WIDTH-2-LUT_ADDR_WIDTH.
  - The carry propagates into the address/quadrant bits before S1 decode. The addition is modulo 2^PHASE_WIDTH.
  - Latency and handshake are unchanged.
- Disabled: pure truncation, and no LFSR logic is instantiated.

Decomposition:
- Package dds_pkg holds:
  - default widths (PHASE_WIDTH, LUT_ADDR_WIDTH, AMP_WIDTH)
  - the LFSR polynomial and seed constants
  - the amp_t typedef
- Sub-module sine_quarter_rom: parameterised ROM with elaboration-time table init, a registered read port, and a clock enable.
- The LFSR stays inline in the top module.

Test Plan (AMP_WIDTH=16, LUT_ADDR_WIDTH=8, PHASE_WIDTH=32, dither off):
- Quadrant points: phase 0x00000000, 0x40000000, 0x80000000, 0xC0000000 with out_ready=1 -> sample_out 101, 32767, -101, -32767 in that order. Each arrives 3 cycles after its input transfer.
- Streaming: phase_in increments by 0x01000000 every cycle for 256 cycles with out_ready=1 -> out_valid continuously high from cycle 3. Samples match the reference model, and the 256-sample sequence is odd-symmetric.
- Backpressure: hold out_ready=0 for 5 cycles with 3 samples in flight -> in_ready=0 and sample_out stable throughout. When out_ready rises, all 3 samples emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 samples in flight -> out_valid=0 and sample_out=0 immediately (asynchronously). No stale sample appears after release.
- Random handshake: 10k random in_valid/out_ready cycles with random phases -> scoreboard reports zero mismatches, zero drops, and zero duplicates.
- Dither on (PHASE_TO_SINE_DITHER_EN): constant phase 0x20000000 -> every sample equals LUT[127] or LUT[128] (positive). The LFSR sequence matches the model seeded with 32'h1.
